// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared T-state, cycle-type and instruction-plan definitions
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_WAIT    = 3'b000,
    ST_T2      = 3'b001,
    ST_T1      = 3'b010,
    ST_T1I     = 3'b011,
    ST_T3      = 3'b100,
    ST_T5      = 3'b101,
    ST_STOPPED = 3'b110,
    ST_T4      = 3'b111
  } tstate_e;

  typedef enum logic [1:0] {
    CYC_PCI = 2'b00,
    CYC_PCC = 2'b01,
    CYC_PCR = 2'b10,
    CYC_PCW = 2'b11
  } cyc_e;

  typedef struct packed {
    logic [1:0] ncyc;
    cyc_e       type2;
    cyc_e       type3;
    logic [2:0] last_len;
  } plan_t;

  localparam int PLAN_W = $bits(plan_t);

  // Bit positions of the decoder class flags in the packed class vector
  localparam int CL_NOP  = 0;
  localparam int CL_HLT  = 1;
  localparam int CL_INC  = 2;
  localparam int CL_DCR  = 3;
  localparam int CL_ROT  = 4;
  localparam int CL_RETC = 5;
  localparam int CL_ALUI = 6;
  localparam int CL_RST  = 7;
  localparam int CL_LRI  = 8;
  localparam int CL_LMI  = 9;
  localparam int CL_RET  = 10;
  localparam int CL_JMPC = 11;
  localparam int CL_CALC = 12;
  localparam int CL_JMP  = 13;
  localparam int CL_CAL  = 14;
  localparam int CL_INP  = 15;
  localparam int CL_OUT  = 16;
  localparam int CL_ALUR = 17;
  localparam int CL_ALUM = 18;
  localparam int CL_LRR  = 19;
  localparam int CL_LRM  = 20;
  localparam int CL_LMR  = 21;
  localparam int NUM_CLASS = 22;

endpackage

// File: rtl/cpu_cycle_plan.sv
// rtl/cpu_cycle_plan.sv - combinational decoder-class to machine-cycle plan
module cpu_cycle_plan
  import cpu_pkg::*;
(
  input  logic [NUM_CLASS-1:0] class_i,
  input  logic                 cond_i,
  output logic [PLAN_W-1:0]    plan_o,
  output logic                 halt_o,
  output logic                 late_cond_o
);

  plan_t p;

  assign plan_o = p;

  // Unknown/empty class falls through to the NOP plan held in the defaults
  always_comb begin
    p           = '{ncyc: 2'd1, type2: CYC_PCI, type3: CYC_PCI, last_len: 3'd5};
    halt_o      = 1'b0;
    late_cond_o = 1'b0;
    if (class_i[CL_HLT]) begin
      halt_o = 1'b1;
    end else if (class_i[CL_NOP] | class_i[CL_LRR] | class_i[CL_INC] |
                 class_i[CL_DCR] | class_i[CL_RET] | class_i[CL_RST]) begin
      p.last_len = 3'd5;
    end else if (class_i[CL_ALUR] | class_i[CL_ROT]) begin
      p.last_len = 3'd4;
    end else if (class_i[CL_RETC]) begin
      p.last_len = cond_i ? 3'd5 : 3'd3;
    end else if (class_i[CL_LRI] | class_i[CL_LRM]) begin
      p.ncyc     = 2'd2;
      p.type2    = CYC_PCR;
      p.last_len = 3'd5;
    end else if (class_i[CL_ALUI] | class_i[CL_ALUM]) begin
      p.ncyc     = 2'd2;
      p.type2    = CYC_PCR;
      p.last_len = 3'd4;
    end else if (class_i[CL_LMR]) begin
      p.ncyc     = 2'd2;
      p.type2    = CYC_PCW;
      p.last_len = 3'd3;
    end else if (class_i[CL_INP] | class_i[CL_OUT]) begin
      p.ncyc     = 2'd2;
      p.type2    = CYC_PCC;
      p.last_len = 3'd3;
    end else if (class_i[CL_LMI]) begin
      p.ncyc     = 2'd3;
      p.type2    = CYC_PCR;
      p.type3    = CYC_PCW;
      p.last_len = 3'd3;
    end else if (class_i[CL_JMP] | class_i[CL_JMPC]) begin
      // Conditional forms assume taken here; the top shortens cycle 3 later
      p.ncyc      = 2'd3;
      p.type2     = CYC_PCR;
      p.type3     = CYC_PCR;
      p.last_len  = 3'd4;
      late_cond_o = class_i[CL_JMPC];
    end else if (class_i[CL_CAL] | class_i[CL_CALC]) begin
      p.ncyc      = 2'd3;
      p.type2     = CYC_PCR;
      p.type3     = CYC_PCR;
      p.last_len  = 3'd5;
      late_cond_o = class_i[CL_CALC];
    end
  end

endmodule

// File: rtl/cpu_timing.sv
// rtl/cpu_timing.sv - machine-cycle and T-state sequencer for the MCS8 core
module cpu_timing
  import cpu_pkg::*;
(
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       READY_I,
  input  logic       INTR_I,
  input  logic       COND_I,
  input  logic       D_NOP_I,
  input  logic       D_HLT_I,
  input  logic       D_INC_I,
  input  logic       D_DCR_I,
  input  logic       D_ROT_I,
  input  logic       D_RETC_I,
  input  logic       D_ALUI_I,
  input  logic       D_RST_I,
  input  logic       D_LRI_I,
  input  logic       D_LMI_I,
  input  logic       D_RET_I,
  input  logic       D_JMPC_I,
  input  logic       D_CALC_I,
  input  logic       D_JMP_I,
  input  logic       D_CAL_I,
  input  logic       D_INP_I,
  input  logic       D_OUT_I,
  input  logic       D_ALUR_I,
  input  logic       D_ALUM_I,
  input  logic       D_LRR_I,
  input  logic       D_LRM_I,
  input  logic       D_LMR_I,
  output logic [2:0] STATE_O,
  output logic [1:0] CYC_O,
  output logic [1:0] CYCNUM_O,
  output logic       IR_LD_O,
  output logic       INTA_O,
  output logic       HALTED_O
);

  logic [NUM_CLASS-1:0] class_w;
  logic [PLAN_W-1:0]    plan_w;
  plan_t                plan_c;
  logic                 halt_c;
  logic                 late_c;

  tstate_e    state_q, state_d;
  cyc_e       cyc_q, cyc_d;
  logic [1:0] cycnum_q, cycnum_d;
  logic       inta_q, inta_d;
  plan_t      plan_q, plan_d;
  logic       late_q, late_d;

  logic       pci_t3;
  logic       last_cyc;
  logic       instr_end;
  plan_t      eff_plan;

  always_comb begin
    class_w           = '0;
    class_w[CL_NOP]   = D_NOP_I;
    class_w[CL_HLT]   = D_HLT_I;
    class_w[CL_INC]   = D_INC_I;
    class_w[CL_DCR]   = D_DCR_I;
    class_w[CL_ROT]   = D_ROT_I;
    class_w[CL_RETC]  = D_RETC_I;
    class_w[CL_ALUI]  = D_ALUI_I;
    class_w[CL_RST]   = D_RST_I;
    class_w[CL_LRI]   = D_LRI_I;
    class_w[CL_LMI]   = D_LMI_I;
    class_w[CL_RET]   = D_RET_I;
    class_w[CL_JMPC]  = D_JMPC_I;
    class_w[CL_CALC]  = D_CALC_I;
    class_w[CL_JMP]   = D_JMP_I;
    class_w[CL_CAL]   = D_CAL_I;
    class_w[CL_INP]   = D_INP_I;
    class_w[CL_OUT]   = D_OUT_I;
    class_w[CL_ALUR]  = D_ALUR_I;
    class_w[CL_ALUM]  = D_ALUM_I;
    class_w[CL_LRR]   = D_LRR_I;
    class_w[CL_LRM]   = D_LRM_I;
    class_w[CL_LMR]   = D_LMR_I;
  end

  cpu_cycle_plan u_plan (
    .class_i     (class_w),
    .cond_i      (COND_I),
    .plan_o      (plan_w),
    .halt_o      (halt_c),
    .late_cond_o (late_c)
  );

  assign plan_c = plan_t'(plan_w);
  assign pci_t3 = (state_q == ST_T3) && (cycnum_q == 2'd1);

  // During PCI T3 the plan register is still stale, so decide from the live plan
  assign eff_plan = pci_t3 ? plan_c : plan_q;
  assign last_cyc = (cycnum_q == eff_plan.ncyc);

  always_comb begin
    state_d   = state_q;
    cyc_d     = cyc_q;
    cycnum_d  = cycnum_q;
    inta_d    = inta_q;
    plan_d    = plan_q;
    late_d    = late_q;
    instr_end = 1'b0;

    if (pci_t3) begin
      plan_d = plan_c;
      late_d = late_c;
    end

    case (state_q)
      ST_T1, ST_T1I: state_d = ST_T2;
      ST_T2, ST_WAIT: state_d = READY_I ? ST_T3 : ST_WAIT;
      ST_T3: begin
        if (pci_t3 && halt_c) begin
          state_d = ST_STOPPED;
          inta_d  = 1'b0;
        end else if (!last_cyc) begin
          state_d  = ST_T1;
          cycnum_d = cycnum_q + 2'd1;
          cyc_d    = (cycnum_q == 2'd1) ? eff_plan.type2 : eff_plan.type3;
          inta_d   = 1'b0;
          // Not-taken JMPC/CALC: cycle 3 still runs but stops at T3
          if (cycnum_q == 2'd2 && late_q && !COND_I) begin
            plan_d.last_len = 3'd3;
          end
        end else if (eff_plan.last_len == 3'd3) begin
          instr_end = 1'b1;
        end else begin
          state_d = ST_T4;
        end
      end
      ST_T4: begin
        if (plan_q.last_len == 3'd5) state_d = ST_T5;
        else                         instr_end = 1'b1;
      end
      ST_T5: instr_end = 1'b1;
      ST_STOPPED: begin
        if (INTR_I) begin
          state_d  = ST_T1I;
          inta_d   = 1'b1;
          cycnum_d = 2'd1;
          cyc_d    = CYC_PCI;
        end
      end
      default: state_d = ST_T1;
    endcase

    if (instr_end) begin
      state_d  = INTR_I ? ST_T1I : ST_T1;
      inta_d   = INTR_I;
      cycnum_d = 2'd1;
      cyc_d    = CYC_PCI;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= ST_T1;
      cyc_q    <= CYC_PCI;
      cycnum_q <= 2'd1;
      inta_q   <= 1'b0;
      plan_q   <= plan_t'('0);
      late_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      cycnum_q <= cycnum_d;
      inta_q   <= inta_d;
      plan_q   <= plan_d;
      late_q   <= late_d;
    end
  end

  assign STATE_O  = state_q;
  assign CYC_O    = cyc_q;
  assign CYCNUM_O = cycnum_q;
  assign IR_LD_O  = pci_t3;
  assign INTA_O   = inta_q;
  assign HALTED_O = (state_q == ST_STOPPED);

endmodule

// File: tb/tb_cpu_timing.sv
// tb/tb_cpu_timing.sv - scoreboard bench for the cpu_timing sequencer
module tb_cpu_timing;

  localparam logic [2:0] S_WAIT = 3'b000, S_T2 = 3'b001, S_T1 = 3'b010, S_T1I = 3'b011;
  localparam logic [2:0] S_T3 = 3'b100, S_T5 = 3'b101, S_STOP = 3'b110, S_T4 = 3'b111;
  localparam logic [1:0] PCI = 2'b00, PCC = 2'b01, PCR = 2'b10, PCW = 2'b11;

  localparam int C_NONE = 0, C_HLT = 1, C_LRR = 2, C_RETC = 3, C_JMP = 4, C_JMPC = 5;
  localparam int C_LMI = 6, C_CAL = 7, C_ALUR = 8, C_INP = 9;

  typedef struct {
    logic [2:0] st;
    logic [1:0] cyc;
    logic [1:0] num;
    logic       inta;
  } exp_t;

  typedef struct {
    logic rst;
    logic ready;
    logic intr;
    logic cond;
    int   cls;
  } stim_t;

  logic clk = 1'b0;
  logic rst, ready, intr, cond;
  int   cur_cls;
  logic f_hlt, f_lrr, f_retc, f_jmp, f_jmpc, f_lmi, f_cal, f_alur, f_inp;
  logic [2:0] state_o;
  logic [1:0] cyc_o, cycnum_o;
  logic ir_ld_o, inta_o, halted_o;

  exp_t  exp_q[$];
  stim_t stim_q[$];
  int checks = 0;
  int errors = 0;
  int step = 0;

  assign f_hlt  = (cur_cls == C_HLT);
  assign f_lrr  = (cur_cls == C_LRR);
  assign f_retc = (cur_cls == C_RETC);
  assign f_jmp  = (cur_cls == C_JMP);
  assign f_jmpc = (cur_cls == C_JMPC);
  assign f_lmi  = (cur_cls == C_LMI);
  assign f_cal  = (cur_cls == C_CAL);
  assign f_alur = (cur_cls == C_ALUR);
  assign f_inp  = (cur_cls == C_INP);

  always #5 clk = ~clk;

  cpu_timing dut (
    .CLK_I(clk), .RST_I(rst), .READY_I(ready), .INTR_I(intr), .COND_I(cond),
    .D_NOP_I(1'b0), .D_HLT_I(f_hlt), .D_INC_I(1'b0), .D_DCR_I(1'b0), .D_ROT_I(1'b0),
    .D_RETC_I(f_retc), .D_ALUI_I(1'b0), .D_RST_I(1'b0), .D_LRI_I(1'b0), .D_LMI_I(f_lmi),
    .D_RET_I(1'b0), .D_JMPC_I(f_jmpc), .D_CALC_I(1'b0), .D_JMP_I(f_jmp), .D_CAL_I(f_cal),
    .D_INP_I(f_inp), .D_OUT_I(1'b0), .D_ALUR_I(f_alur), .D_ALUM_I(1'b0), .D_LRR_I(f_lrr),
    .D_LRM_I(1'b0), .D_LMR_I(1'b0),
    .STATE_O(state_o), .CYC_O(cyc_o), .CYCNUM_O(cycnum_o),
    .IR_LD_O(ir_ld_o), .INTA_O(inta_o), .HALTED_O(halted_o)
  );

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s step=%0d got=%0h exp=%0h", tag, step, got, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_state(input logic [2:0] st, input logic [1:0] cyc, input logic [1:0] num,
                            input logic inta, input logic r, input logic rdy, input logic irq,
                            input logic cnd, input int cls);
    exp_t  e;
    stim_t s;
    e.st = st; e.cyc = cyc; e.num = num; e.inta = inta;
    s.rst = r; s.ready = rdy; s.intr = irq; s.cond = cnd; s.cls = cls;
    exp_q.push_back(e);
    stim_q.push_back(s);
  endtask

  // One machine cycle as derived from the state rules: T1/T1I, T2, WAITs, T3[, T4[, T5]]
  task automatic push_cycle(input logic [1:0] cyc, input logic [1:0] num, input int len,
                            input int waits, input logic inta, input int cls, input logic cnd,
                            input logic intr_end, input logic noise);
    push_state((num == 2'd1 && inta) ? S_T1I : S_T1, cyc, num, inta, 1'b0, 1'b1, noise, cnd, cls);
    push_state(S_T2, cyc, num, inta, 1'b0, (waits == 0), noise, cnd, cls);
    for (int k = 0; k < waits; k++)
      push_state(S_WAIT, cyc, num, inta, 1'b0, (k == waits - 1), noise, cnd, cls);
    push_state(S_T3, cyc, num, inta, 1'b0, 1'b1, (len == 3) ? intr_end : noise, cnd, cls);
    if (len >= 4)
      push_state(S_T4, cyc, num, inta, 1'b0, 1'b1, (len == 4) ? intr_end : noise, cnd, cls);
    if (len == 5)
      push_state(S_T5, cyc, num, inta, 1'b0, 1'b1, intr_end, cnd, cls);
  endtask

  initial begin
    exp_t  e;
    stim_t s;
    rst = 1'b1; ready = 1'b1; intr = 1'b1; cond = 1'b0; cur_cls = C_NONE;
    tick();
    tick();
    check_val("rst_state", {5'd0, state_o}, {5'd0, S_T1});
    check_val("rst_cyc", {6'd0, cyc_o}, {6'd0, PCI});
    check_val("rst_num", {6'd0, cycnum_o}, 8'd1);
    check_val("rst_irld", {7'd0, ir_ld_o}, 8'd0);
    check_val("rst_inta", {7'd0, inta_o}, 8'd0);
    check_val("rst_halt", {7'd0, halted_o}, 8'd0);
    rst = 1'b0; intr = 1'b0;

    // LRR: 5 states
    push_cycle(PCI, 2'd1, 5, 0, 1'b0, C_LRR, 1'b0, 1'b0, 1'b0);
    // JMP with two WAIT states in cycle 2, interrupt at the end
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_JMP, 1'b0, 1'b0, 1'b0);
    push_cycle(PCR, 2'd2, 3, 2, 1'b0, C_JMP, 1'b0, 1'b0, 1'b0);
    push_cycle(PCR, 2'd3, 4, 0, 1'b0, C_JMP, 1'b0, 1'b1, 1'b0);
    // Interrupt PCI decodes RETC not taken: 3-state minimum instruction
    push_cycle(PCI, 2'd1, 3, 0, 1'b1, C_RETC, 1'b0, 1'b0, 1'b0);
    // JMPC: cond high at PCI T3 but low at cycle-2 T3, so cycle 3 ends at T3
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_JMPC, 1'b1, 1'b0, 1'b0);
    push_cycle(PCR, 2'd2, 3, 0, 1'b0, C_JMPC, 1'b0, 1'b0, 1'b0);
    push_cycle(PCR, 2'd3, 3, 0, 1'b0, C_JMPC, 1'b1, 1'b0, 1'b0);
    // LMI with INTR noise everywhere except the final state
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_LMI, 1'b0, 1'b1, 1'b1);
    push_cycle(PCR, 2'd2, 3, 0, 1'b0, C_LMI, 1'b0, 1'b1, 1'b1);
    push_cycle(PCW, 2'd3, 3, 0, 1'b0, C_LMI, 1'b0, 1'b0, 1'b1);
    // RETC taken
    push_cycle(PCI, 2'd1, 5, 0, 1'b0, C_RETC, 1'b1, 1'b0, 1'b0);
    // CAL: 11-state maximum
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_CAL, 1'b0, 1'b0, 1'b0);
    push_cycle(PCR, 2'd2, 3, 0, 1'b0, C_CAL, 1'b0, 1'b0, 1'b0);
    push_cycle(PCR, 2'd3, 5, 0, 1'b0, C_CAL, 1'b0, 1'b0, 1'b0);
    // HLT, five idle STOPPED clocks, then interrupt into an ALUR
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_HLT, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      push_state(S_STOP, PCI, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE);
    push_state(S_STOP, PCI, 2'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, C_NONE);
    push_cycle(PCI, 2'd1, 4, 0, 1'b1, C_ALUR, 1'b0, 1'b0, 1'b0);
    // INP: PCI then PCC
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_INP, 1'b0, 1'b0, 1'b0);
    push_cycle(PCC, 2'd2, 3, 0, 1'b0, C_INP, 1'b0, 1'b0, 1'b0);
    // CAL interrupted by reset during a cycle-2 WAIT with INTR high
    push_cycle(PCI, 2'd1, 3, 0, 1'b0, C_CAL, 1'b0, 1'b0, 1'b0);
    push_state(S_T1, PCR, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_CAL);
    push_state(S_T2, PCR, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, C_CAL);
    push_state(S_WAIT, PCR, 2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, C_CAL);
    push_state(S_T1, PCI, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, C_NONE);

    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_val("state", {5'd0, state_o}, {5'd0, e.st});
      if (e.st != S_STOP) begin
        check_val("cyc", {6'd0, cyc_o}, {6'd0, e.cyc});
        check_val("cycnum", {6'd0, cycnum_o}, {6'd0, e.num});
      end
      check_val("ir_ld", {7'd0, ir_ld_o}, {7'd0, (e.st == S_T3 && e.num == 2'd1)});
      check_val("inta", {7'd0, inta_o}, {7'd0, e.inta});
      check_val("halted", {7'd0, halted_o}, {7'd0, (e.st == S_STOP)});
      if (stim_q.size() != 0) begin
        s = stim_q.pop_front();
        rst = s.rst; ready = s.ready; intr = s.intr; cond = s.cond; cur_cls = s.cls;
      end
      tick();
      step++;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
